// File: rtl/tdm_demux_if.sv
// Bus bundle between a 4-slot TDM stream source and tdm_demux_1_to_4.
// With TDM_DEMUX_PARITY_EN defined, din_par and par_err are added.
interface tdm_demux_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic [W-1:0]     din;
    logic             din_valid;
    logic             frame_start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic [W-1:0]     d;
    logic             out_valid;
    logic [1:0]       sel;
    logic             busy;
    logic             frame_err;
    logic [CNT_W-1:0] frame_cnt;
`ifdef TDM_DEMUX_PARITY_EN
    logic             din_par;
    logic             par_err;

    modport master (
        output din, din_valid, frame_start, din_par,
        input  a, b, c, d, out_valid, sel, busy, frame_err, frame_cnt, par_err
    );
    modport slave (
        input  din, din_valid, frame_start, din_par,
        output a, b, c, d, out_valid, sel, busy, frame_err, frame_cnt, par_err
    );
`else
    modport master (
        output din, din_valid, frame_start,
        input  a, b, c, d, out_valid, sel, busy, frame_err, frame_cnt
    );
    modport slave (
        input  din, din_valid, frame_start,
        output a, b, c, d, out_valid, sel, busy, frame_err, frame_cnt
    );
`endif
endinterface

// File: rtl/tdm_demux_1_to_4.sv
// 1-to-4 TDM demultiplexer: collects slots a..d after frame_start, then updates all lanes at once.
// Optional even-parity check on din is enabled with TDM_DEMUX_PARITY_EN.
module tdm_demux_1_to_4 #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    tdm_demux_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for a frame_start sample (slot 0)
    // COLLECT | slots 0..sel-1 held in shadow registers
    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [W-1:0]     sh0_q, sh1_q, sh2_q, sh0_d, sh1_d, sh2_d;
    logic [W-1:0]     a_q, b_q, c_q, d_q, a_d, b_d, c_d, d_d;
    logic             ov_q, ov_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_ok;
`ifdef TDM_DEMUX_PARITY_EN
    logic             sample_bad;
    logic             bad_q, bad_d, perr_q, perr_d;

    assign sample_bad = bus.din_par ^ (^bus.din);
    assign frame_ok   = !(bad_q | sample_bad);
`else
    assign frame_ok   = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef TDM_DEMUX_PARITY_EN
            bad_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef TDM_DEMUX_PARITY_EN
            bad_q   <= bad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        ov_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef TDM_DEMUX_PARITY_EN
        bad_d   = bad_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.din_valid) begin
                    if (bus.frame_start) begin
                        sh0_d   = bus.din;
                        sel_d   = 2'd1;
                        state_d = COLLECT;
`ifdef TDM_DEMUX_PARITY_EN
                        bad_d   = sample_bad;
                        perr_d  = perr_q | sample_bad;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.din_valid) begin
`ifdef TDM_DEMUX_PARITY_EN
                    perr_d = perr_q | sample_bad;
`endif
                    if (bus.frame_start) begin
                        // resync: drop the partial frame, this sample becomes slot 0
                        err_d = 1'b1;
                        sh0_d = bus.din;
                        sel_d = 2'd1;
`ifdef TDM_DEMUX_PARITY_EN
                        bad_d = sample_bad;
`endif
                    end else begin
                        sel_d = sel_q + 2'd1;
                        case (sel_q)
                            2'd1: sh1_d = bus.din;
                            2'd2: sh2_d = bus.din;
                            2'd3: begin
                                cnt_d   = cnt_q + 1'b1;
                                state_d = IDLE;
                                if (frame_ok) begin
                                    a_d  = sh0_q;
                                    b_d  = sh1_q;
                                    c_d  = sh2_q;
                                    d_d  = bus.din;
                                    ov_d = 1'b1;
                                end
                            end
                            default: ;
                        endcase
`ifdef TDM_DEMUX_PARITY_EN
                        bad_d = bad_q | sample_bad;
`endif
                    end
                end
            end
        endcase
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.c         = c_q;
    assign bus.d         = d_q;
    assign bus.out_valid = ov_q;
    assign bus.frame_err = err_q;
    assign bus.frame_cnt = cnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == COLLECT);
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.par_err   = perr_q;
`endif
endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Scoreboard bench for tdm_demux_1_to_4: a frame-level queue model predicts completed frames,
// a free-running monitor pops them on out_valid and checks per-cycle status outputs.
module tb_tdm_demux_1_to_4;
    localparam int W     = 8;
    localparam int CNT_W = 8;
`ifdef TDM_DEMUX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [W-1:0]     c;
        logic [W-1:0]     d;
        logic [CNT_W-1:0] cnt;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    tdm_demux_if #(.W(W), .CNT_W(CNT_W)) bus ();

    tdm_demux_1_to_4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: frames as sample queues, expectations for the state after the next edge
    logic [W-1:0]     part[$];
    logic             pbad;
    frame_t           sb[$];
    logic [1:0]       exp_sel;
    logic             exp_busy, exp_ov, exp_err, exp_perr;
    logic [W-1:0]     exp_a, exp_b, exp_c, exp_d;
    logic [CNT_W-1:0] exp_cnt;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        part.delete();
        sb.delete();
        pbad     = 1'b0;
        exp_sel  = '0;
        exp_busy = 1'b0;
        exp_ov   = 1'b0;
        exp_err  = 1'b0;
        exp_perr = 1'b0;
        exp_a    = '0;
        exp_b    = '0;
        exp_c    = '0;
        exp_d    = '0;
        exp_cnt  = '0;
    endtask

    task automatic step(input logic v, input logic fs, input logic [W-1:0] dv, input logic pb);
        logic pbx;
        frame_t f;
        pbx = PAR_EN & pb;
        @(posedge clk);
        #3;
        bus.din_valid   = v;
        bus.frame_start = fs;
        bus.din         = dv;
`ifdef TDM_DEMUX_PARITY_EN
        bus.din_par     = (^dv) ^ pbx;
`endif
        exp_ov  = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            if (fs) begin
                if (part.size() != 0) exp_err = 1'b1;
                part.delete();
                part.push_back(dv);
                pbad = pbx;
                if (pbx) exp_perr = 1'b1;
            end else if (part.size() == 0) begin
                exp_err = 1'b1;
            end else begin
                part.push_back(dv);
                pbad = pbad | pbx;
                if (pbx) exp_perr = 1'b1;
                if (part.size() == 4) begin
                    exp_cnt = exp_cnt + 1'b1;
                    if (!pbad) begin
                        exp_a  = part[0];
                        exp_b  = part[1];
                        exp_c  = part[2];
                        exp_d  = part[3];
                        exp_ov = 1'b1;
                        f = '{a: part[0], b: part[1], c: part[2], d: part[3], cnt: exp_cnt};
                        sb.push_back(f);
                    end
                    part.delete();
                end
            end
        end
        exp_sel  = 2'(part.size());
        exp_busy = (part.size() != 0);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #3;
        rst_n           = 1'b0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
        model_reset();
        #1;
        // outputs must clear without waiting for a clock edge
        check("async_rst_sel",  32'(bus.sel), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_lanes", {bus.a, bus.b, bus.c, bus.d}, 32'd0);
        check("async_rst_cnt",  32'(bus.frame_cnt), 32'd0);
        repeat (cycles) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] s0, input logic [W-1:0] s1,
                              input logic [W-1:0] s2, input logic [W-1:0] s3, input int gap);
        step(1'b1, 1'b1, s0, 1'b0);
        repeat (gap) step(1'b0, 1'b0, 8'hEE, 1'b0);
        step(1'b1, 1'b0, s1, 1'b0);
        repeat (gap) step(1'b0, 1'b1, 8'hEE, 1'b0);
        step(1'b1, 1'b0, s2, 1'b0);
        repeat (gap) step(1'b0, 1'b0, 8'hEE, 1'b0);
        step(1'b1, 1'b0, s3, 1'b0);
    endtask

    // monitor: compares each cycle, pops the scoreboard whenever the DUT presents a frame
    initial begin
        frame_t f;
        forever begin
            @(posedge clk);
            #1;
            check("sel",       32'(bus.sel), 32'(exp_sel));
            check("busy",      32'(bus.busy), 32'(exp_busy));
            check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            check("frame_err", 32'(bus.frame_err), 32'(exp_err));
            check("lanes",     {bus.a, bus.b, bus.c, bus.d}, {exp_a, exp_b, exp_c, exp_d});
            check("frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
`ifdef TDM_DEMUX_PARITY_EN
            check("par_err",   32'(bus.par_err), 32'(exp_perr));
`endif
            if (bus.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_frame: got out_valid=1 expected no pending frame at %0t", $time);
                end else begin
                    f = sb.pop_front();
                    check("sb_lanes", {bus.a, bus.b, bus.c, bus.d}, {f.a, f.b, f.c, f.d});
                    check("sb_cnt",   32'(bus.frame_cnt), 32'(f.cnt));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v, fs, pb;
        bus.din         = '0;
        bus.din_valid   = 1'b0;
        bus.frame_start = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        bus.din_par     = 1'b0;
`endif
        model_reset();
        #1 rst_n = 1'b0;
        #30;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // partial frame lost to reset, then a clean frame
        step(1'b1, 1'b1, 8'h99, 1'b0);
        step(1'b1, 1'b0, 8'h98, 1'b0);
        do_reset(2);
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0);

        // gapped frame
        send_frame(8'hA0, 8'hA1, 8'hA2, 8'hA3, 2);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // resync mid-frame
        step(1'b1, 1'b1, 8'h01, 1'b0);
        step(1'b1, 1'b0, 8'h02, 1'b0);
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // orphan sample in IDLE, then reset mid-frame
        step(1'b1, 1'b0, 8'h55, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h66, 1'b0);
        step(1'b1, 1'b0, 8'h77, 1'b0);
        do_reset(1);

        // 257 back-to-back frames: counter wraps to 1
        for (int i = 0; i < 257; i++)
            send_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("wrap_cnt", 32'(exp_cnt), 32'd1);

`ifdef TDM_DEMUX_PARITY_EN
        send_frame(8'hC0, 8'hC1, 8'hC2, 8'hC3, 0);
        step(1'b1, 1'b1, 8'hD0, 1'b0);
        step(1'b1, 1'b0, 8'hD1, 1'b0);
        step(1'b1, 1'b0, 8'hD2, 1'b1);
        step(1'b1, 1'b0, 8'hD3, 1'b0);
        send_frame(8'hE0, 8'hE1, 8'hE2, 8'hE3, 1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
`endif

        // randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset(1);
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                fs = v && ((part.size() == 0) ? ($urandom_range(0, 7) != 0)
                                               : ($urandom_range(0, 9) == 0));
                pb = ($urandom_range(0, 59) == 0);
                step(v, fs, 8'($urandom), pb);
            end
        end

        repeat (4) step(1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
